// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding request to AXI4-Lite master bridge.
// Optional watchdog: define AXIL_BRIDGE_TIMEOUT_EN.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("axil_master_bridge: DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("axil_master_bridge: TIMEOUT_CYCLES out of range");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic aw_done, w_done;

`ifdef AXIL_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        waiting;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    aw_done      = !awvalid_q || m_axi_awready;
    w_done       = !wvalid_q || m_axi_wready;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        wstrb_d     = req_wstrb;
        req_ready_d = 1'b0;
        if (req_we) begin
          state_d   = WR_AW_W;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RD_AR;
          arvalid_d = 1'b1;
        end
      end
      // AW and W complete independently; leave once both have landed.
      WR_AW_W: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: if (m_axi_bvalid) begin
        bready_d     = 1'b0;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = (m_axi_bresp != AXI_OKAY);
        resp_rdata_d = '0;
      end
      RD_AR: if (m_axi_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_R;
      end
      RD_R: if (m_axi_rvalid) begin
        rready_d     = 1'b0;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = (m_axi_rresp != AXI_OKAY);
        resp_rdata_d = m_axi_rdata;
      end
      RESP: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_BRIDGE_TIMEOUT_EN
    waiting   = (state_q == WR_AW_W) || (state_q == WR_B) ||
                (state_q == RD_AR) || (state_q == RD_R);
    tmo_cnt_d = waiting ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
    // Normal progress on the final cycle wins over the watchdog.
    if (waiting && state_d == state_q && tmo_cnt_q == TMO_LAST) begin
      state_d      = RESP;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      resp_valid_d = 1'b1;
      resp_err_d   = (AXI_SLVERR != AXI_OKAY);
      resp_rdata_d = '0;
    end
    if (state_d != state_q) tmo_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifdef AXIL_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: directed table, random traffic vs. memory model, reset/timeout cases.
module tb_axil_master_bridge;

`ifdef AXIL_BRIDGE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [12:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_master_bridge #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic        err;
    logic        tmo;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // -1: not checked
  } vec_t;

  int pass_cnt = 0, chk_cnt = 0;

  // slave configuration and observation
  int cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic cfg_err;
  int cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, proto_err = 0;
  int resp_cnt = 0, resp_cyc = 0;
  logic [31:0] resp_rdata_s;
  logic        resp_err_s;
  logic [12:0] sl_awaddr, sl_araddr;
  logic [31:0] sl_wdata;
  logic [3:0]  sl_wstrb;
  logic [31:0] smem [int];
  logic [31:0] ref_mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  // Slave + monitor: everything evaluated at the falling edge.
  initial begin
    logic p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [12:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata, cur;
    logic [3:0]  p_wstrb;
    logic aw_done, w_done, ar_done;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    {p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready} = '0;
    {p_awaddr, p_araddr, p_wdata, p_wstrb} = '0;
    {aw_done, w_done, ar_done} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
    m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        resp_cnt++; resp_cyc = cyc; resp_rdata_s = resp_rdata; resp_err_s = resp_err;
      end
      if (rst) begin
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
        {p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready} = '0;
        {aw_done, w_done, ar_done} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
        continue;
      end
      if (p_awvalid && m_axi_awready) begin aw_hs++; aw_done = 1; sl_awaddr = p_awaddr; end
      if (p_wvalid && m_axi_wready) begin w_hs++; w_done = 1; sl_wdata = p_wdata; sl_wstrb = p_wstrb; end
      if (p_arvalid && m_axi_arready) begin ar_hs++; ar_done = 1; sl_araddr = p_araddr; end
      if (p_bready && m_axi_bvalid) begin b_hs++; m_axi_bvalid = 0; aw_done = 0; w_done = 0; b_wait = 0; end
      if (p_rready && m_axi_rvalid) begin r_hs++; m_axi_rvalid = 0; ar_done = 0; r_wait = 0; end
      if (p_awvalid && !m_axi_awready && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) proto_err++;
      if (p_wvalid && !m_axi_wready &&
          (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb)) proto_err++;
      if (p_arvalid && !m_axi_arready && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) proto_err++;
      if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) proto_err++;
      if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= cfg_aw_dly); aw_wait++; end
      else begin m_axi_awready = 0; aw_wait = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_wait >= cfg_w_dly); w_wait++; end
      else begin m_axi_wready = 0; w_wait = 0; end
      if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= cfg_ar_dly); ar_wait++; end
      else begin m_axi_arready = 0; ar_wait = 0; end
      if (aw_done && w_done && !m_axi_bvalid) begin
        if (b_wait >= cfg_b_dly) begin
          cur = smem.exists(int'(sl_awaddr >> 2)) ? smem[int'(sl_awaddr >> 2)] : 32'h0;
          for (int b = 0; b < 4; b++) if (sl_wstrb[b]) cur[8*b +: 8] = sl_wdata[8*b +: 8];
          smem[int'(sl_awaddr >> 2)] = cur;
          m_axi_bvalid = 1; m_axi_bresp = cfg_err ? 2'b10 : 2'b00;
        end else b_wait++;
      end
      if (ar_done && !m_axi_rvalid) begin
        if (r_wait >= cfg_r_dly) begin
          m_axi_rdata = smem.exists(int'(sl_araddr >> 2)) ? smem[int'(sl_araddr >> 2)] : 32'h0;
          m_axi_rvalid = 1; m_axi_rresp = cfg_err ? 2'b10 : 2'b00;
        end else r_wait++;
      end
      p_awvalid = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_wvalid = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arvalid = m_axi_arvalid; p_araddr = m_axi_araddr;
      p_bready = m_axi_bready; p_rready = m_axi_rready;
    end
  end

  task automatic run_txn(input string tag, input vec_t v);
    int aw0, w0, b0, ar0, r0, rc0, pe0, drv, n;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_err = v.err;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; rc0 = resp_cnt; pe0 = proto_err;
    @(negedge clk); #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    drv = cyc;
    @(negedge clk); #1;
    req_valid = 0;
    n = 0;
    while (resp_cnt == rc0 && n < 300) begin @(negedge clk); #1; n++; end
    chk({tag, ".resp_count"}, resp_cnt - rc0, 1);
    chk({tag, ".rdata"}, resp_rdata_s, v.exp_rdata);
    chk({tag, ".err"}, resp_err_s, v.exp_err);
    if (v.exp_lat >= 0) chk({tag, ".latency"}, resp_cyc - drv, v.exp_lat);
    chk({tag, ".aw_hs"}, aw_hs - aw0, v.we ? 1 : 0);
    chk({tag, ".w_hs"}, w_hs - w0, v.we ? 1 : 0);
    chk({tag, ".b_hs"}, b_hs - b0, v.we ? 1 : 0);
    chk({tag, ".ar_hs"}, ar_hs - ar0, (!v.we && !v.tmo) ? 1 : 0);
    chk({tag, ".r_hs"}, r_hs - r0, (!v.we && !v.tmo) ? 1 : 0);
    if (v.we) begin
      chk({tag, ".awaddr"}, sl_awaddr, v.addr);
      chk({tag, ".wdata"}, sl_wdata, v.wdata);
      chk({tag, ".wstrb"}, sl_wstrb, v.wstrb);
    end else if (!v.tmo) chk({tag, ".araddr"}, sl_araddr, v.addr);
    if (!v.tmo) chk({tag, ".protocol"}, proto_err - pe0, 0);
    chk({tag, ".valids_low"},
        {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    // reference memory: last write wins per byte lane
    if (v.we) begin
      logic [31:0] cur;
      cur = ref_mem.exists(int'(v.addr >> 2)) ? ref_mem[int'(v.addr >> 2)] : 32'h0;
      for (int b = 0; b < 4; b++) if (v.wstrb[b]) cur[8*b +: 8] = v.wdata[8*b +: 8];
      ref_mem[int'(v.addr >> 2)] = cur;
    end
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int n, rc0;
    //          we  addr      wdata         strb   aw w b ar r err tmo exp_rdata     err lat
    tbl[0] = '{1'b1, 13'h0040, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 0, 1'b0, 1'b0, 32'h0,        1'b0, -1};
    tbl[1] = '{1'b0, 13'h0040, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0,  3};
    tbl[2] = '{1'b1, 13'h0080, 32'h12345678, 4'hF, 2, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0,        1'b0,  5};
    tbl[3] = '{1'b0, 13'h0080, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h12345678, 1'b1,  3};
    tbl[4] = '{1'b1, 13'h0080, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0,        1'b0,  3};
    tbl[5] = '{1'b0, 13'h0080, 32'h0,        4'h0, 0, 0, 0, 1, 2, 1'b0, 1'b0, 32'h12BB56DD, 1'b0,  6};
    tbl[6] = '{1'b1, 13'h1FFC, 32'hFFFFFFFF, 4'hF, 1, 1, 3, 0, 0, 1'b1, 1'b0, 32'h0,        1'b1,  7};
    tbl[7] = '{1'b0, 13'h1FFC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0,  3};

    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0; cfg_err = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.axi_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    chk("rst.resp", {resp_valid, resp_err, resp_rdata}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst.req_ready_after", req_ready, 1);

    for (int i = 0; i < 8; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // random traffic; expected data from reference memory, latency from slave delays
    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.addr = 13'h100 + 13'($urandom_range(0, 15) * 4);
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(1, 15));
      v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3); v.b_dly = $urandom_range(0, 3);
      v.ar_dly = $urandom_range(0, 3); v.r_dly = $urandom_range(0, 3);
      v.err = ($urandom_range(0, 3) == 0);
      v.tmo = 1'b0;
      v.exp_err = v.err;
      if (v.we) begin
        v.exp_rdata = 32'h0;
        v.exp_lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
      end else begin
        v.exp_rdata = ref_mem.exists(int'(v.addr >> 2)) ? ref_mem[int'(v.addr >> 2)] : 32'h0;
        v.exp_lat = 3 + v.ar_dly + v.r_dly;
      end
      run_txn($sformatf("rnd%0d", i), v);
    end

    // reset while waiting for read data
    cfg_ar_dly = 0; cfg_r_dly = 40; cfg_err = 0;
    @(negedge clk); #1;
    req_valid = 1; req_we = 0; req_addr = 13'h0040;
    @(negedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!m_axi_rready && n < 20) begin @(negedge clk); #1; n++; end
    chk("rst_mid.in_rd_r", m_axi_rready, 1);
    rc0 = resp_cnt;
    rst = 1; #1;
    chk("rst_mid.axi_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    chk("rst_mid.resp", {resp_valid, resp_err, resp_rdata}, 0);
    @(negedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_mid.req_ready", req_ready, 1);
    repeat (50) @(negedge clk);
    #1;
    chk("rst_mid.no_resp", resp_cnt - rc0, 0);

    tbl[0] = '{1'b0, 13'h0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    run_txn("post_rst_read", tbl[0]);

`ifdef AXIL_BRIDGE_TIMEOUT_EN
    // slave never accepts AR: watchdog fires TMO cycles after entering RD_AR
    tbl[1] = '{1'b0, 13'h0040, 32'h0, 4'h0, 0, 0, 0, 5000, 0, 1'b0, 1'b1, 32'h0, 1'b1, TMO + 1};
    run_txn("timeout_ar", tbl[1]);
    tbl[1] = '{1'b0, 13'h0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    run_txn("after_timeout", tbl[1]);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
